ext_bus_arbiter: RTL
====================

// Module: ext_bus_arbiter
// PURPOSE
//  Sequences the shared external 16-bit multiplexed memory bus (address latches, OEb, WEb_lo/hi)
//  and shares it between two requesters: the CPU core (port C) and the Wishbone debug host (port W).
//  Each access runs three phases: low address latch, high address latch, then a timed data phase.
//  Sits between tholin_riscv / the Wishbone slave logic and the io_out/io_in/io_oeb pads.
// PARAMETERS
//  ADDR_W       24  external address width in bits, legal 17..32; bits [ADDR_W-1:16] go in the high latch
//  WAIT_CYCLES  1   extra data-phase cycles, legal 0..15; the data phase lasts WAIT_CYCLES+1 cycles
// PORTS
//  wb_clk_i     in   1       clock, all state on rising edge
//  wb_rst_i     in   1       asynchronous reset, active-high
//  c_req        in   1       CPU request; held high until c_ack
//  c_we         in   1       CPU write (1) / read (0)
//  c_be         in   2       CPU byte enables, [0]=bits 7:0, [1]=bits 15:8
//  c_addr       in   ADDR_W  CPU halfword address
//  c_wdata      in   16      CPU write data
//  c_ack        out  1       one-cycle completion strobe to the CPU
//  w_req,w_we,w_be,w_addr,w_wdata,w_ack   same roles for the Wishbone host port
//  rdata        out  16      read data; valid in the ack cycle, holds until the next read completes
//  bus_out      out  16      pad output data/address
//  bus_in       in   16      pad input data
//  bus_dir      out  1       1 = pads input (io_oeb high), 0 = driving
//  le_lo        out  1       low address latch enable, active-high
//  le_hi        out  1       high address latch enable, active-high
//  OEb          out  1       read strobe, active-low
//  WEb_lo       out  1       low-byte write strobe, active-low
//  WEb_hi       out  1       high-byte write strobe, active-low
//  busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, bus_dir=1, le_lo=le_hi=0, OEb=WEb_lo=WEb_hi=1,
//   c_ack=w_ack=0, busy=0, rdata=0, bus_out=0, last_grant=W (so C wins the first tie).
//  All pad controls are registered outputs, with no combinational path from the req inputs.
//  States: IDLE -> ALO -> AHI -> ACC (WAIT_CYCLES+1 cycles) -> TURN -> IDLE.
//  IDLE: requests are sampled only here. If only one req is high, grant it. If both are high,
//   grant the port not in last_grant. Latch we/be/addr/wdata of the winner and update last_grant.
//  ALO (1 cycle): bus_dir=0, bus_out=addr[15:0], le_lo=1.
//  AHI (1 cycle): bus_dir=0, bus_out={zero-extend addr[ADDR_W-1:16]}, le_hi=1.
//  ACC read: bus_dir=1, OEb=0. Capture bus_in into rdata on the last ACC cycle.
//  ACC write: bus_dir=0, bus_out=wdata, WEb_lo=~be[0], WEb_hi=~be[1].
//   With be=00, timing is unchanged and no strobe fires.
//  A wait counter (4 bits) loads WAIT_CYCLES on entry to ACC and decrements each cycle.
//   ACC exits when the counter is 0.
//  TURN (1 cycle): bus_dir=1, all strobes and latch enables inactive.
//   The granted port's ack is high in this cycle only. The req inputs are not sampled.
//  Latency from the req-sampled cycle to ack = WAIT_CYCLES+4 cycles. Back-to-back accesses are separated by 1 IDLE cycle.
//  Strobe safety: OEb and WEb are never low in the same cycle. le_lo/le_hi are never high during ACC.
//   bus_dir never goes 1->0 without passing through TURN or IDLE.
//  Dropping req mid-access is a protocol violation: the access still completes and acks.
//  Reset mid-access aborts the access immediately. No ack is issued and strobes release asynchronously.
// TESTING
//  1. CPU read 0x012345, WAIT_CYCLES=1, bus_in=0xBEEF: le_lo with bus_out=0x2345, then le_hi with 0x0001.
//     OEb low 2 cycles; c_ack at +5 with rdata=0xBEEF.
//  2. W write 0x00ABCD, data 0x5A5A, be=10: WEb_hi low 2 cycles, WEb_lo stays 1, bus_dir=0 through ACC.
//     w_ack once; c_ack stays 0.
//  3. c_req and w_req rise together and are held 3 accesses: grant order C,W,C.
//     One IDLE cycle between TURN and the next ALO.
//  4. WAIT_CYCLES=0 write with be=00: ACC lasts 1 cycle with no WEb strobe, ack at +4.
//     Then WAIT_CYCLES=15 read: OEb low 16 cycles.
//  5. Assert wb_rst_i during ACC of a write: WEb_lo/hi go 1 and bus_dir goes 1 before the next edge.
//     No ack. After release, a fresh C read completes normally.
//  6. Random C/W traffic for 10k cycles against a bus SRAM model: data matches the model.
//     Strobe-exclusion assertions hold and each ack maps 1:1 to a granted request.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Two-port arbiter and phase sequencer for the shared 16-bit multiplexed external memory bus.
// Each access runs low address latch, high address latch, a timed data phase and a turnaround cycle.
module ext_bus_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_be,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [15:0]       c_wdata,
  output logic              c_ack,
  input  logic              w_req,
  input  logic              w_we,
  input  logic [1:0]        w_be,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_wdata,
  output logic              w_ack,
  output logic [15:0]       rdata,
  output logic [15:0]       bus_out,
  input  logic [15:0]       bus_in,
  output logic              bus_dir,
  output logic              le_lo,
  output logic              le_hi,
  output logic              OEb,
  output logic              WEb_lo,
  output logic              WEb_hi,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_ALO, S_AHI, S_ACC, S_TURN} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt, wait_cnt_nxt;
  logic                grant_w, grant_w_nxt;
  logic                last_w, last_w_nxt;
  logic                acc_we, acc_we_nxt;
  logic [1:0]          acc_be, acc_be_nxt;
  logic [ADDR_W-1:0]   acc_addr, acc_addr_nxt;
  logic [15:0]         acc_wdata, acc_wdata_nxt;
  logic [15:0]         rdata_nxt, bus_out_nxt, addr_hi;
  logic                bus_dir_nxt, le_lo_nxt, le_hi_nxt, oeb_nxt, web_lo_nxt, web_hi_nxt;
  logic                c_ack_nxt, w_ack_nxt;
  logic                pick_w, drive_acc;

  // A tie goes to whichever port did not win last time.
  assign pick_w = w_req && (!c_req || !last_w);

  always_comb begin
    addr_hi = '0;
    addr_hi[ADDR_W-17:0] = acc_addr[ADDR_W-1:16];
  end

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    grant_w_nxt   = grant_w;
    last_w_nxt    = last_w;
    acc_we_nxt    = acc_we;
    acc_be_nxt    = acc_be;
    acc_addr_nxt  = acc_addr;
    acc_wdata_nxt = acc_wdata;
    rdata_nxt     = rdata;
    bus_out_nxt   = bus_out;
    bus_dir_nxt   = 1'b1;
    le_lo_nxt     = 1'b0;
    le_hi_nxt     = 1'b0;
    oeb_nxt       = 1'b1;
    web_lo_nxt    = 1'b1;
    web_hi_nxt    = 1'b1;
    c_ack_nxt     = 1'b0;
    w_ack_nxt     = 1'b0;
    drive_acc     = 1'b0;

    case (state)
      S_IDLE: begin
        if (c_req || w_req) begin
          grant_w_nxt   = pick_w;
          last_w_nxt    = pick_w;
          acc_we_nxt    = pick_w ? w_we    : c_we;
          acc_be_nxt    = pick_w ? w_be    : c_be;
          acc_addr_nxt  = pick_w ? w_addr  : c_addr;
          acc_wdata_nxt = pick_w ? w_wdata : c_wdata;
          bus_out_nxt   = pick_w ? w_addr[15:0] : c_addr[15:0];
          bus_dir_nxt   = 1'b0;
          le_lo_nxt     = 1'b1;
          state_nxt     = S_ALO;
        end
      end
      S_ALO: begin
        bus_out_nxt = addr_hi;
        bus_dir_nxt = 1'b0;
        le_hi_nxt   = 1'b1;
        state_nxt   = S_AHI;
      end
      S_AHI: begin
        wait_cnt_nxt = WAIT_INIT;
        drive_acc    = 1'b1;
        state_nxt    = S_ACC;
      end
      S_ACC: begin
        if (wait_cnt == 4'd0) begin
          c_ack_nxt = !grant_w;
          w_ack_nxt = grant_w;
          if (!acc_we) rdata_nxt = bus_in;
          state_nxt = S_TURN;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          drive_acc    = 1'b1;
        end
      end
      S_TURN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Pad values for a cycle spent in the data phase.
    if (drive_acc) begin
      if (acc_we) begin
        bus_dir_nxt = 1'b0;
        bus_out_nxt = acc_wdata;
        web_lo_nxt  = ~acc_be[0];
        web_hi_nxt  = ~acc_be[1];
      end else begin
        oeb_nxt = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      grant_w   <= 1'b0;
      last_w    <= 1'b1;
      acc_we    <= 1'b0;
      acc_be    <= '0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      rdata     <= '0;
      bus_out   <= '0;
      bus_dir   <= 1'b1;
      le_lo     <= 1'b0;
      le_hi     <= 1'b0;
      OEb       <= 1'b1;
      WEb_lo    <= 1'b1;
      WEb_hi    <= 1'b1;
      c_ack     <= 1'b0;
      w_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      grant_w   <= grant_w_nxt;
      last_w    <= last_w_nxt;
      acc_we    <= acc_we_nxt;
      acc_be    <= acc_be_nxt;
      acc_addr  <= acc_addr_nxt;
      acc_wdata <= acc_wdata_nxt;
      rdata     <= rdata_nxt;
      bus_out   <= bus_out_nxt;
      bus_dir   <= bus_dir_nxt;
      le_lo     <= le_lo_nxt;
      le_hi     <= le_hi_nxt;
      OEb       <= oeb_nxt;
      WEb_lo    <= web_lo_nxt;
      WEb_hi    <= web_hi_nxt;
      c_ack     <= c_ack_nxt;
      w_ack     <= w_ack_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule
